key_debouncer: RTL



---
 rtl/key_debouncer.sv | 82 ++++++++
 1 files changed

// File: rtl/key_debouncer.sv
// key_debouncer: conditions raw, bouncing key inputs into a clean,
// clock-synchronous key-level vector with per-key press/release pulses.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   key_raw      raw key pins, 1 = pressed (asynchronous, may bounce)
//   key_level    debounced key state, 1 = held
//   key_press    1-cycle pulse when key_level rises
//   key_release  1-cycle pulse when key_level falls
//   any_key      OR of key_level, registered alongside it
//
// Each key is independent. Its effective state (stable low/high, counting
// up/down) is implied by key_level and a non-zero counter, so no separate
// state register exists.
module key_debouncer #(
  parameter int unsigned N_KEYS          = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              any_key
);

  // Last counter value before a change is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [CNT_W-1:0]  cnt     [N_KEYS];
  logic [CNT_W-1:0]  cnt_nxt [N_KEYS];
  logic [N_KEYS-1:0] level_nxt;

  // Next-state: agreement clears the counter, mismatch counts up and
  // flips the level on the DEBOUNCE_CYCLES-th consecutive mismatch.
  always_comb begin
    level_nxt = key_level;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != key_level[i]) begin
        if (cnt[i] == CNT_LAST) begin
          level_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // State and output registers; event pulses come from the level edge
  // being committed this cycle, so they line up with the new key_level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= '0;
      sync2       <= '0;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      any_key     <= 1'b0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1       <= key_raw;
      sync2       <= sync1;
      key_level   <= level_nxt;
      key_press   <= level_nxt & ~key_level;
      key_release <= ~level_nxt & key_level;
      any_key     <= |level_nxt;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule
